// File: rtl/lbm_frame_sequencer_if.sv
// Control/status bundle between the PS control side, the DDR pixel paths,
// the compute core and the LBM frame sequencer.
interface lbm_frame_sequencer_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int ITER_WIDTH    = 16
) ();
  // Requests and completion events toward the sequencer
  logic                     start;
  logic                     abort;
  logic [ITER_WIDTH-1:0]    num_iters;
  logic                     load_beat;
  logic                     load_last;
  logic                     compute_done;
  logic                     unload_done;

  // Phase pulses and status from the sequencer
  logic                     load_start;
  logic                     compute_start;
  logic                     unload_start;
  logic [1:0]               bram_sel;
  logic [ADDRESS_WIDTH-1:0] pixel_addr;
  logic [ITER_WIDTH-1:0]    iter_count;
  logic                     busy;
  logic                     done;
  logic                     frame_err;

  // Environment side: issues requests/completions, observes phase status
  modport master (
    output start, abort, num_iters, load_beat, load_last, compute_done, unload_done,
    input  load_start, compute_start, unload_start, bram_sel, pixel_addr,
           iter_count, busy, done, frame_err
  );

  // Sequencer side
  modport slave (
    input  start, abort, num_iters, load_beat, load_last, compute_done, unload_done,
    output load_start, compute_start, unload_start, bram_sel, pixel_addr,
           iter_count, busy, done, frame_err
  );
endinterface

// File: rtl/lbm_frame_sequencer.sv
// Phase controller for one LBM run: LOAD a frame from the DDR stream,
// run num_iters collision/stream iterations, then UNLOAD the frame.
// Owns the pixel-BRAM port select and checks the loaded frame length.
// Every output is a register loaded from the next-state decode.
module lbm_frame_sequencer #(
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int ITER_WIDTH    = 16
) (
  input logic                  m00_axis_aclk,
  input logic                  m00_axis_aresetn,
  lbm_frame_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE_ISSUE,
    COMPUTE_WAIT,
    UNLOAD,
    DONE
  } state_t;

  // Index of the final beat of a correctly sized frame
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  // BRAM port owners
  localparam logic [1:0] SEL_DDR_IN  = 2'd0;
  localparam logic [1:0] SEL_CORE    = 2'd1;
  localparam logic [1:0] SEL_DDR_OUT = 2'd2;

  state_t                   state;
  state_t                   state_next;
  logic [ITER_WIDTH-1:0]    iters_target;
  logic [ITER_WIDTH-1:0]    iters_target_next;
  logic [ADDRESS_WIDTH-1:0] pixel_addr;
  logic [ADDRESS_WIDTH-1:0] pixel_addr_next;
  logic [ITER_WIDTH-1:0]    iter_count;
  logic [ITER_WIDTH-1:0]    iter_count_next;
  logic                     frame_err;
  logic                     frame_err_next;
  logic                     load_start;
  logic                     load_start_next;
  logic                     compute_start;
  logic                     compute_start_next;
  logic                     unload_start;
  logic                     unload_start_next;
  logic                     done;
  logic                     done_next;
  logic                     busy;
  logic                     busy_next;
  logic [1:0]               bram_sel;
  logic [1:0]               bram_sel_next;

  // Iteration counter advance; pinned at the latched target so a stray
  // extra completion can never push the count past it.
  function automatic logic [ITER_WIDTH-1:0] sat_iter_inc(
    input logic [ITER_WIDTH-1:0] count,
    input logic [ITER_WIDTH-1:0] limit
  );
    logic [ITER_WIDTH-1:0] result;
    if (count >= limit) begin
      result = limit;
    end else begin
      result = count + ITER_WIDTH'(1);
    end
    return result;
  endfunction

  // BRAM owner for a given phase; DONE keeps the output path selected
  // for its single cycle, IDLE hands the port back to the DDR input.
  function automatic logic [1:0] owner_of(input state_t s);
    logic [1:0] sel;
    sel = SEL_DDR_IN;
    case (s)
      COMPUTE_ISSUE, COMPUTE_WAIT: sel = SEL_CORE;
      UNLOAD, DONE:                sel = SEL_DDR_OUT;
      default:                     sel = SEL_DDR_IN;
    endcase
    return sel;
  endfunction

  // Next-state, run bookkeeping and registered-output decode
  always_comb begin
    state_next        = state;
    iters_target_next = iters_target;
    pixel_addr_next   = pixel_addr;
    iter_count_next   = iter_count;
    frame_err_next    = frame_err;

    if (bus.abort) begin
      // Abort beats every other input: no counting, no error update
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_next        = LOAD;
            iters_target_next = bus.num_iters;
            pixel_addr_next   = '0;
            iter_count_next   = '0;
            frame_err_next    = 1'b0;
          end
        end

        LOAD: begin
          if (bus.load_beat) begin
            pixel_addr_next = pixel_addr + ADDRESS_WIDTH'(1);
            if (bus.load_last && (pixel_addr == LAST_ADDR)) begin
              state_next = (iters_target != '0) ? COMPUTE_ISSUE : UNLOAD;
            end else if (bus.load_last || (pixel_addr >= LAST_ADDR)) begin
              // tlast before the final index is a short frame; reaching
              // the final index without tlast is a long frame
              frame_err_next = 1'b1;
              state_next     = IDLE;
            end
          end
        end

        COMPUTE_ISSUE: begin
          state_next = COMPUTE_WAIT;
        end

        COMPUTE_WAIT: begin
          if (bus.compute_done) begin
            iter_count_next = sat_iter_inc(iter_count, iters_target);
            state_next = (iter_count_next == iters_target) ? UNLOAD : COMPUTE_ISSUE;
          end
        end

        UNLOAD: begin
          if (bus.unload_done) begin
            state_next = DONE;
          end
        end

        DONE: begin
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // Pulses are derived from the transition so they appear in the first
    // cycle of the phase they announce; an abort forces IDLE and so
    // suppresses all of them.
    load_start_next    = (state == IDLE) && (state_next == LOAD);
    compute_start_next = (state_next == COMPUTE_ISSUE);
    unload_start_next  = (state_next == UNLOAD) && (state != UNLOAD);
    done_next          = (state_next == DONE);
    busy_next          = (state_next != IDLE);
    bram_sel_next      = owner_of(state_next);
  end

  // State register
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run bookkeeping and output registers
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      iters_target  <= '0;
      pixel_addr    <= '0;
      iter_count    <= '0;
      frame_err     <= 1'b0;
      load_start    <= 1'b0;
      compute_start <= 1'b0;
      unload_start  <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      bram_sel      <= SEL_DDR_IN;
    end else begin
      iters_target  <= iters_target_next;
      pixel_addr    <= pixel_addr_next;
      iter_count    <= iter_count_next;
      frame_err     <= frame_err_next;
      load_start    <= load_start_next;
      compute_start <= compute_start_next;
      unload_start  <= unload_start_next;
      done          <= done_next;
      busy          <= busy_next;
      bram_sel      <= bram_sel_next;
    end
  end

  assign bus.load_start    = load_start;
  assign bus.compute_start = compute_start;
  assign bus.unload_start  = unload_start;
  assign bus.bram_sel      = bram_sel;
  assign bus.pixel_addr    = pixel_addr;
  assign bus.iter_count    = iter_count;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.frame_err     = frame_err;

endmodule

// File: tb/tb_lbm_frame_sequencer.sv
// Testbench for lbm_frame_sequencer: a cycle table for IDLE/LOAD control
// corners, hand sequences for the multi-cycle run scenarios, and randomized
// runs whose pulse counts and end state come from a run-level model.
module tb_lbm_frame_sequencer;
  localparam int DEPTH = 2500;
  localparam int AW    = 12;
  localparam int IW    = 16;
  localparam int NV    = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lbm_frame_sequencer_if #(.ADDRESS_WIDTH(AW), .ITER_WIDTH(IW)) bus ();

  lbm_frame_sequencer #(
    .DEPTH(DEPTH),
    .ADDRESS_WIDTH(AW),
    .ITER_WIDTH(IW)
  ) dut (
    .m00_axis_aclk(clk),
    .m00_axis_aresetn(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Pulse tallies sampled mid-cycle
  int n_ls = 0;
  int n_cs = 0;
  int n_us = 0;
  int n_dn = 0;

  always @(negedge clk) begin
    if (bus.load_start)    n_ls <= n_ls + 1;
    if (bus.compute_start) n_cs <= n_cs + 1;
    if (bus.unload_start)  n_us <= n_us + 1;
    if (bus.done)          n_dn <= n_dn + 1;
  end

  // Cycle vectors: inputs for one cycle, outputs expected after its edge
  typedef struct {
    int start;
    int abort;
    int num_iters;
    int beat;
    int last;
    int cdone;
    int udone;
    int e_busy;
    int e_ls;
    int e_sel;
    int e_addr;
    int e_err;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.num_iters    = '0;
    bus.load_beat    = 1'b0;
    bus.load_last    = 1'b0;
    bus.compute_done = 1'b0;
    bus.unload_done  = 1'b0;
  endtask

  // One cycle of inputs the current phase must ignore (never the one it consumes)
  task automatic noise_cycle(input int phase, input bit noisy);
    if (noisy) begin
      bus.start        = 1'($urandom_range(0, 1));
      bus.load_beat    = (phase != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.load_last    = 1'($urandom_range(0, 1));
      bus.compute_done = (phase != 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.unload_done  = (phase != 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    step();
    bus.start        = 1'b0;
    bus.load_beat    = 1'b0;
    bus.load_last    = 1'b0;
    bus.compute_done = 1'b0;
    bus.unload_done  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(bus.busy), 0);
    check({tag, "_ls"},     32'(bus.load_start), 0);
    check({tag, "_cs"},     32'(bus.compute_start), 0);
    check({tag, "_us"},     32'(bus.unload_start), 0);
    check({tag, "_done"},   32'(bus.done), 0);
    check({tag, "_sel"},    32'(bus.bram_sel), 0);
    check({tag, "_addr"},   32'(bus.pixel_addr), 0);
    check({tag, "_iter"},   32'(bus.iter_count), 0);
    check({tag, "_err"},    32'(bus.frame_err), 0);
  endtask

  // Streams nbeats pixels; tlast on the final one if asked, abort alongside it if asked
  task automatic load_frame(input int nbeats, input bit with_last, input bit abort_last, input bit noisy);
    for (int i = 0; i < nbeats; i++) begin
      if (noisy && $urandom_range(0, 7) == 0) noise_cycle(0, 1'b1);
      if (i == nbeats / 2) check("load_addr", 32'(bus.pixel_addr), 32'(i));
      bus.load_beat = 1'b1;
      bus.load_last = with_last && (i == nbeats - 1);
      bus.abort     = abort_last && (i == nbeats - 1);
      step();
      bus.load_beat = 1'b0;
      bus.load_last = 1'b0;
      bus.abort     = 1'b0;
    end
  endtask

  // kind: 0 good frame, 1 short (tlast on beat nbeats-1), 2 long (no tlast),
  // 3 abort on beat nbeats-1. abort_at: iteration index to abort at, or -1.
  task automatic run_scenario(input int iters, input int kind, input int nbeats,
                              input int abort_at, input bit noisy);
    int ls0, cs0, us0, dn0;
    int exp_cs, exp_us, exp_dn, exp_iter, exp_err, d;
    bit good, aborted;
    ls0 = n_ls;
    cs0 = n_cs;
    us0 = n_us;
    dn0 = n_dn;

    // Run-level expectations
    good     = (kind == 0);
    aborted  = good && (abort_at >= 0) && (abort_at < iters);
    exp_cs   = !good ? 0 : (aborted ? abort_at + 1 : iters);
    exp_us   = (good && !aborted) ? 1 : 0;
    exp_dn   = exp_us;
    exp_iter = !good ? 0 : (aborted ? abort_at : iters);
    exp_err  = (kind == 1 || kind == 2) ? 1 : 0;

    clear_inputs();
    bus.num_iters = IW'(iters);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    check("run_load_start", 32'(bus.load_start), 1);
    check("run_err_cleared", 32'(bus.frame_err), 0);
    check("run_busy", 32'(bus.busy), 1);
    if (noisy) bus.num_iters = IW'($urandom_range(0, 65535));

    load_frame(nbeats, (kind == 0 || kind == 1), (kind == 3), noisy);

    if (good) begin
      for (int k = 0; k < iters; k++) begin
        check("cstart", 32'(bus.compute_start), 1);
        check("sel_core", 32'(bus.bram_sel), 1);
        step();
        check("cstart_single", 32'(bus.compute_start), 0);
        d = noisy ? $urandom_range(0, 3) : 1;
        repeat (d) noise_cycle(1, noisy);
        bus.compute_done = 1'b1;
        bus.abort        = (k == abort_at);
        step();
        bus.compute_done = 1'b0;
        bus.abort        = 1'b0;
        if (k == abort_at) begin
          check("abort_busy", 32'(bus.busy), 0);
          check("abort_iter", 32'(bus.iter_count), 32'(k));
          break;
        end
        check("iter_count", 32'(bus.iter_count), 32'(k + 1));
      end
      if (!aborted) begin
        check("ustart", 32'(bus.unload_start), 1);
        check("sel_out", 32'(bus.bram_sel), 2);
        d = noisy ? $urandom_range(0, 3) : 2;
        repeat (d) noise_cycle(2, noisy);
        bus.unload_done = 1'b1;
        step();
        bus.unload_done = 1'b0;
        check("done_pulse", 32'(bus.done), 1);
        check("done_busy", 32'(bus.busy), 1);
        step();
        check("done_single", 32'(bus.done), 0);
        check("idle_busy", 32'(bus.busy), 0);
      end
    end else begin
      check("bad_busy", 32'(bus.busy), 0);
    end

    repeat (4) step();
    check("n_load_start", 32'(n_ls - ls0), 1);
    check("n_compute_start", 32'(n_cs - cs0), 32'(exp_cs));
    check("n_unload_start", 32'(n_us - us0), 32'(exp_us));
    check("n_done", 32'(n_dn - dn0), 32'(exp_dn));
    check("end_iter", 32'(bus.iter_count), 32'(exp_iter));
    check("end_err", 32'(bus.frame_err), 32'(exp_err));
    check("end_busy", 32'(bus.busy), 0);
    check("end_sel", 32'(bus.bram_sel), 0);
  endtask

  // Timeout guard
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dn0;

    //           st ab num bt ls cd ud | busy ls sel addr err
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 1, 1, 1,   0, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 2, 0, 0, 0, 0,   1, 1, 0, 0, 0};
    vecs[5]  = '{1, 0, 2, 1, 0, 0, 0,   1, 0, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 2, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2, 0};
    vecs[8]  = '{0, 0, 0, 0, 1, 1, 1,   1, 0, 0, 2, 0};
    vecs[9]  = '{0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 3, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1};
    vecs[11] = '{1, 1, 3, 0, 0, 0, 0,   0, 0, 0, 3, 1};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};

    clear_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Cycle table: IDLE filtering, abort priority, short frame, sticky error
    for (int i = 0; i < NV; i++) begin
      bus.start        = 1'(vecs[i].start);
      bus.abort        = 1'(vecs[i].abort);
      bus.num_iters    = IW'(vecs[i].num_iters);
      bus.load_beat    = 1'(vecs[i].beat);
      bus.load_last    = 1'(vecs[i].last);
      bus.compute_done = 1'(vecs[i].cdone);
      bus.unload_done  = 1'(vecs[i].udone);
      step();
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_ls", i), 32'(bus.load_start), 32'(vecs[i].e_ls));
      check($sformatf("vec%0d_sel", i), 32'(bus.bram_sel), 32'(vecs[i].e_sel));
      check($sformatf("vec%0d_addr", i), 32'(bus.pixel_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_err", i), 32'(bus.frame_err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d_cs", i), 32'(bus.compute_start), 0);
      check($sformatf("vec%0d_done", i), 32'(bus.done), 0);
    end
    clear_inputs();

    // Nominal, zero iterations, short frame, error cleared by next start, long frame
    run_scenario(3, 0, DEPTH, -1, 1'b0);
    run_scenario(0, 0, DEPTH, -1, 1'b0);
    run_scenario(2, 1, 1001, -1, 1'b0);
    run_scenario(1, 0, DEPTH, -1, 1'b0);
    run_scenario(2, 2, DEPTH, -1, 1'b0);
    // Abort together with compute_done on iteration 2 of 5
    run_scenario(5, 0, DEPTH, 1, 1'b0);

    // Asynchronous reset while unloading
    clear_inputs();
    bus.num_iters = IW'(1);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    load_frame(DEPTH, 1'b1, 1'b0, 1'b0);
    check("rst_cstart", 32'(bus.compute_start), 1);
    step();
    bus.compute_done = 1'b1;
    step();
    bus.compute_done = 1'b0;
    check("rst_ustart", 32'(bus.unload_start), 1);
    step();
    check("rst_pre_busy", 32'(bus.busy), 1);
    check("rst_pre_sel", 32'(bus.bram_sel), 2);
    dn0 = n_dn;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    step();
    rst_n = 1'b1;
    bus.unload_done = 1'b1;
    step();
    bus.unload_done = 1'b0;
    check("rst_late_done", 32'(bus.done), 0);
    check("rst_late_busy", 32'(bus.busy), 0);
    repeat (2) step();
    check("rst_no_done", 32'(n_dn - dn0), 0);
    run_scenario(2, 0, DEPTH, -1, 1'b1);

    // Randomized runs with ignored-input noise
    for (int r = 0; r < 6; r++) begin
      int it, kind, nb, ab;
      it   = $urandom_range(0, 4);
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      nb   = (kind == 1 || kind == 3) ? $urandom_range(1, DEPTH - 1) : DEPTH;
      ab   = (it > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, it - 1) : -1;
      run_scenario(it, kind, nb, ab, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
